// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor command sequencer.
// The ramp helper widens to 9 bits so a step never wraps past 0 or 127.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BRAKE, ST_FAULT} state_t;

    localparam int PSV_W  = 7;
    localparam int STE_W  = 8;
    localparam int EDGE_W = 16;

    function automatic logic [PSV_W-1:0] ramp_toward(
        input logic [PSV_W-1:0] cur,
        input logic [PSV_W-1:0] tgt,
        input logic [PSV_W+1:0] step
    );
        logic [PSV_W+1:0] up;
        logic [PSV_W+1:0] dn;
        up = {2'b00, cur} + step;
        dn = {2'b00, cur} - step;
        if (cur < tgt)
            ramp_toward = (up > {2'b00, tgt}) ? tgt : up[PSV_W-1:0];
        else if (cur > tgt)
            // A borrow shows up in the top bit; clamp to the target instead.
            ramp_toward = (dn[PSV_W+1] || (dn < {2'b00, tgt})) ? tgt : dn[PSV_W-1:0];
        else
            ramp_toward = cur;
    endfunction

endpackage

// File: rtl/ctrl_tick_gen.sv
// Control-rate tick: one-cycle pulse every TICK_DIV clocks.
module ctrl_tick_gen #(
    parameter int TICK_DIV = 15625
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/motor_drive_ctrl.sv
// Motor command sequencer: command handshake, soft speed ramp, watchdog brake
// and encoder stall detection ahead of the steering/PWM datapath.
//
// state    | meaning
// ST_IDLE  | stopped, waiting for a non-zero speed or brake command
// ST_RUN   | ramping/holding psv toward target, watchdog and stall armed
// ST_BRAKE | brk asserted, psv forced 0, held BRAKE_TICKS ticks
// ST_FAULT | stall latched, commands refused until clr_fault
module motor_drive_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 15625,
    parameter int RAMP_STEP   = 2,
    parameter int WDOG_TICKS  = 4000,
    parameter int BRAKE_TICKS = 800,
    parameter int STALL_MIN   = 20,
    parameter int STALL_TICKS = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [PSV_W-1:0]  cmd_acc,
    input  logic [STE_W-1:0]  cmd_ste,
    input  logic              cmd_brk,
    input  logic              clr_fault,
    input  logic [EDGE_W-1:0] edge_l,
    input  logic [EDGE_W-1:0] edge_r,
    output logic [PSV_W-1:0]  psv,
    output logic [STE_W-1:0]  ste,
    output logic              brk,
    output state_t            state,
    output logic              fault,
    output logic              stall_l,
    output logic              stall_r
);
    localparam int WD_W = $clog2(WDOG_TICKS + 1);
    localparam int BR_W = $clog2(BRAKE_TICKS + 1);
    localparam int SC_W = $clog2(STALL_TICKS + 1);
    localparam logic [WD_W-1:0]  WDOG_LAST  = WD_W'(WDOG_TICKS);
    localparam logic [BR_W-1:0]  BRAKE_LAST = BR_W'(BRAKE_TICKS);
    localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(STALL_TICKS);
    localparam logic [PSV_W-1:0] ARM_MIN    = PSV_W'(STALL_MIN);
    localparam logic [PSV_W+1:0] STEP       = (PSV_W + 2)'(RAMP_STEP);

    logic              tick;
    logic              accept;
    logic              armed;
    logic              hit_l, hit_r, stall_hit, wdog_hit;
    logic [PSV_W-1:0]  target, tgt_eff;
    logic [WD_W-1:0]   wdog_cnt, wd_inc;
    logic [BR_W-1:0]   brake_cnt, br_inc;
    logic [SC_W-1:0]   cnt_l, cnt_r, cnt_l_inc, cnt_r_inc;
    logic [EDGE_W-1:0] snap_l, snap_r;

    ctrl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd_ready = (state != ST_FAULT);
    assign accept    = cmd_valid && cmd_ready;
    assign armed     = (state == ST_RUN) && (psv >= ARM_MIN);
    assign cnt_l_inc = cnt_l + SC_W'(1);
    assign cnt_r_inc = cnt_r + SC_W'(1);
    assign hit_l     = armed && tick && (edge_l == snap_l) && (cnt_l_inc == STALL_LAST);
    assign hit_r     = armed && tick && (edge_r == snap_r) && (cnt_r_inc == STALL_LAST);
    assign stall_hit = hit_l || hit_r;
    assign wd_inc    = wdog_cnt + WD_W'(1);
    assign wdog_hit  = (state == ST_RUN) && tick && (wd_inc == WDOG_LAST);
    assign br_inc    = brake_cnt + BR_W'(1);
    // A tick landing on the accept cycle already ramps toward the new target.
    assign tgt_eff   = accept ? cmd_acc : target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            psv       <= '0;
            ste       <= '0;
            brk       <= 1'b0;
            fault     <= 1'b0;
            stall_l   <= 1'b0;
            stall_r   <= 1'b0;
            target    <= '0;
            wdog_cnt  <= '0;
            brake_cnt <= '0;
            cnt_l     <= '0;
            cnt_r     <= '0;
            snap_l    <= '0;
            snap_r    <= '0;
        end else begin
            if (!armed) begin
                snap_l <= edge_l;
                snap_r <= edge_r;
                cnt_l  <= '0;
                cnt_r  <= '0;
            end else if (tick) begin
                if (edge_l == snap_l) cnt_l <= cnt_l_inc;
                else begin cnt_l <= '0; snap_l <= edge_l; end
                if (edge_r == snap_r) cnt_r <= cnt_r_inc;
                else begin cnt_r <= '0; snap_r <= edge_r; end
            end

            if (state != ST_RUN || accept) wdog_cnt <= '0;
            else if (tick)                 wdog_cnt <= wd_inc;

            if (accept) ste <= cmd_ste;

            case (state)
                ST_IDLE: begin
                    psv <= '0;
                    brk <= 1'b0;
                    if (accept && cmd_brk) begin
                        state     <= ST_BRAKE;
                        target    <= '0;
                        brk       <= 1'b1;
                        brake_cnt <= '0;
                    end else if (accept && cmd_acc != '0) begin
                        state  <= ST_RUN;
                        target <= cmd_acc;
                    end
                end
                ST_RUN: begin
                    if (stall_hit) begin
                        state   <= ST_FAULT;
                        psv     <= '0;
                        ste     <= '0;
                        target  <= '0;
                        brk     <= 1'b1;
                        fault   <= 1'b1;
                        stall_l <= hit_l;
                        stall_r <= hit_r;
                    end else if (wdog_hit || (accept && cmd_brk)) begin
                        state     <= ST_BRAKE;
                        psv       <= '0;
                        target    <= '0;
                        brk       <= 1'b1;
                        brake_cnt <= '0;
                    end else begin
                        if (accept) target <= cmd_acc;
                        if (tick) begin
                            if (psv == '0 && tgt_eff == '0) state <= ST_IDLE;
                            else psv <= ramp_toward(psv, tgt_eff, STEP);
                        end
                    end
                end
                ST_BRAKE: begin
                    if (tick) begin
                        if (br_inc == BRAKE_LAST) begin
                            state     <= ST_IDLE;
                            brk       <= 1'b0;
                            brake_cnt <= '0;
                        end else begin
                            brake_cnt <= br_inc;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clr_fault) begin
                        state   <= ST_IDLE;
                        brk     <= 1'b0;
                        fault   <= 1'b0;
                        stall_l <= 1'b0;
                        stall_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Self-checking bench for motor_drive_ctrl: randomized commands and encoder
// activity checked against tick-level expectations derived from the ramp rules.
module tb_motor_drive_ctrl;
    import motor_ctrl_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int RAMP_STEP   = 2;
    localparam int WDOG_TICKS  = 50;
    localparam int BRAKE_TICKS = 5;
    localparam int STALL_MIN   = 20;
    localparam int STALL_TICKS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_acc = '0;
    logic [7:0]  cmd_ste = '0;
    logic        cmd_brk = 1'b0;
    logic        clr_fault = 1'b0;
    logic [15:0] edge_l = '0;
    logic [15:0] edge_r = '0;
    logic [6:0]  psv;
    logic [7:0]  ste;
    logic        brk;
    state_t      state;
    logic        fault;
    logic        stall_l;
    logic        stall_r;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tk = 0;
    int m_psv = 0;
    bit run_l = 1'b1;
    bit run_r = 1'b1;

    motor_drive_ctrl #(
        .TICK_DIV(TICK_DIV), .RAMP_STEP(RAMP_STEP), .WDOG_TICKS(WDOG_TICKS),
        .BRAKE_TICKS(BRAKE_TICKS), .STALL_MIN(STALL_MIN), .STALL_TICKS(STALL_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_acc(cmd_acc), .cmd_ste(cmd_ste), .cmd_brk(cmd_brk), .clr_fault(clr_fault),
        .edge_l(edge_l), .edge_r(edge_r), .psv(psv), .ste(ste), .brk(brk),
        .state(state), .fault(fault), .stall_l(stall_l), .stall_r(stall_r)
    );

    always #4 clk = ~clk;

    // Speed after one control tick, straight from the ramp rule.
    function automatic int ref_ramp(input int p, input int t);
        if (p < t) return (p + RAMP_STEP > t) ? t : p + RAMP_STEP;
        if (p > t) return (p - RAMP_STEP < t) ? t : p - RAMP_STEP;
        return p;
    endfunction

    // One clock; tick edges are every TICK_DIV-th edge after reset release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % TICK_DIV == 0) tk++;
        if (run_l) edge_l = edge_l + 16'($urandom_range(1, 3));
        if (run_r) edge_r = edge_r + 16'($urandom_range(1, 3));
    endtask

    task automatic wait_until(input int t);
        while (tk < t) step();
    endtask

    task automatic align();
        while ((cyc + 1) % TICK_DIV == 0) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        tk = 0;
        m_psv = 0;
        run_l = 1'b1;
        run_r = 1'b1;
    endtask

    task automatic send(input int acc, input int s, input bit b);
        cmd_acc = 7'(acc);
        cmd_ste = 8'(s);
        cmd_brk = b;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_brk = 1'b0;
    endtask

    task automatic ramp_to(input int t, input string tag);
        int guard;
        guard = 0;
        while (m_psv != t && guard < 100) begin
            wait_until(tk + 1);
            guard++;
            m_psv = ref_ramp(m_psv, t);
            checks++;
            if (psv !== 7'(m_psv)) begin
                errors++;
                $display("FAIL %s_ramp: psv=%0d expected %0d", tag, psv, m_psv);
            end
        end
        wait_until(tk + 1);
        checks++;
        if (psv !== 7'(t)) begin
            errors++;
            $display("FAIL %s_hold: psv=%0d expected %0d", tag, psv, t);
        end
    endtask

    task automatic test_reset();
        int s;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (state !== ST_IDLE || psv !== 7'd0 || ste !== 8'd0 || brk !== 1'b0 ||
            fault !== 1'b0 || stall_l !== 1'b0 || stall_r !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals: state=%0d psv=%0d ste=%0d brk=%0d fault=%0d stl=%0d str=%0d rdy=%0d expected 0 0 0 0 0 0 0 1",
                     state, psv, ste, brk, fault, stall_l, stall_r, cmd_ready);
        end
        rst = 1'b0;
        cyc = 0;
        tk = 0;
        m_psv = 0;
        s = $urandom_range(1, 255);
        align();
        send(40, s, 1'b0);
        checks++;
        if (ste !== 8'(s)) begin
            errors++;
            $display("FAIL reset_ste_latency: ste=%0d expected %0d", ste, s);
        end
        ramp_to(40, "reset_prep");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (psv !== 7'd0 || brk !== 1'b0 || state !== ST_IDLE || cmd_ready !== 1'b1 || ste !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: psv=%0d brk=%0d state=%0d rdy=%0d ste=%0d expected 0 0 0 1 0",
                     psv, brk, state, cmd_ready, ste);
        end
        step();
        rst = 1'b0;
        cyc = 0;
        tk = 0;
        m_psv = 0;
    endtask

    task automatic test_ramp();
        int s, t;
        apply_reset();
        s = $urandom_range(0, 255);
        align();
        send(10, s, 1'b0);
        checks++;
        if (ste !== 8'(s) || psv !== 7'd0 || state !== ST_RUN) begin
            errors++;
            $display("FAIL ramp_accept: ste=%0d psv=%0d state=%0d expected %0d 0 %0d", ste, psv, state, s, ST_RUN);
        end
        ramp_to(10, "ramp10");
        align();
        send(3, s, 1'b0);
        ramp_to(3, "ramp3");
        for (int i = 0; i < 3; i++) begin
            t = $urandom_range(1, 90);
            s = $urandom_range(0, 255);
            align();
            send(t, s, 1'b0);
            checks++;
            if (ste !== 8'(s)) begin
                errors++;
                $display("FAIL ramp_rand_ste: ste=%0d expected %0d", ste, s);
            end
            ramp_to(t, "ramp_rand");
        end
        t = (m_psv > 45) ? $urandom_range(1, 30) : $urandom_range(60, 90);
        while ((cyc + 1) % TICK_DIV != 0) step();
        send(t, 0, 1'b0);
        m_psv = ref_ramp(m_psv, t);
        checks++;
        if (psv !== 7'(m_psv)) begin
            errors++;
            $display("FAIL ramp_tick_accept: psv=%0d expected %0d", psv, m_psv);
        end
        ramp_to(t, "ramp_tick");
        align();
        send(0, 0, 1'b0);
        ramp_to(0, "ramp_zero");
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL ramp_to_idle: state=%0d expected %0d", state, ST_IDLE);
        end
    endtask

    task automatic test_brake();
        int s, t0;
        apply_reset();
        align();
        send(10, 0, 1'b0);
        ramp_to(10, "brake_prep");
        s = $urandom_range(0, 255);
        align();
        send(100, s, 1'b1);
        t0 = tk;
        checks++;
        if (psv !== 7'd0 || brk !== 1'b1 || state !== ST_BRAKE || ste !== 8'(s)) begin
            errors++;
            $display("FAIL brake_entry: psv=%0d brk=%0d state=%0d ste=%0d expected 0 1 %0d %0d",
                     psv, brk, state, ste, ST_BRAKE, s);
        end
        s = $urandom_range(0, 255);
        align();
        send(50, s, 1'b0);
        checks++;
        if (ste !== 8'(s) || psv !== 7'd0 || state !== ST_BRAKE) begin
            errors++;
            $display("FAIL brake_cmd: ste=%0d psv=%0d state=%0d expected %0d 0 %0d", ste, psv, state, s, ST_BRAKE);
        end
        wait_until(t0 + BRAKE_TICKS - 1);
        checks++;
        if (state !== ST_BRAKE || brk !== 1'b1 || psv !== 7'd0) begin
            errors++;
            $display("FAIL brake_hold: state=%0d brk=%0d psv=%0d expected %0d 1 0", state, brk, psv, ST_BRAKE);
        end
        wait_until(t0 + BRAKE_TICKS);
        checks++;
        if (state !== ST_IDLE || brk !== 1'b0 || psv !== 7'd0) begin
            errors++;
            $display("FAIL brake_exit: state=%0d brk=%0d psv=%0d expected %0d 0 0", state, brk, psv, ST_IDLE);
        end
    endtask

    task automatic test_watchdog();
        int t0;
        apply_reset();
        align();
        send(30, $urandom_range(0, 255), 1'b0);
        t0 = tk;
        ramp_to(30, "wdog_prep");
        wait_until(t0 + WDOG_TICKS - 1);
        checks++;
        if (state !== ST_RUN || psv !== 7'd30 || brk !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: state=%0d psv=%0d brk=%0d expected %0d 30 0", state, psv, brk, ST_RUN);
        end
        wait_until(t0 + WDOG_TICKS);
        checks++;
        if (state !== ST_BRAKE || psv !== 7'd0 || brk !== 1'b1) begin
            errors++;
            $display("FAIL wdog_expire: state=%0d psv=%0d brk=%0d expected %0d 0 1", state, psv, brk, ST_BRAKE);
        end
    endtask

    task automatic test_stall(input bit right_side);
        int t0;
        apply_reset();
        run_l = right_side;
        run_r = !right_side;
        align();
        send(30, $urandom_range(1, 255), 1'b0);
        t0 = tk;
        wait_until(t0 + 12);
        if (right_side) edge_l = 16'hFFFD;
        else            edge_r = 16'hFFFD;
        // first tick where psv >= STALL_MIN, then STALL_TICKS more ticks
        wait_until(t0 + STALL_MIN / RAMP_STEP + STALL_TICKS - 1);
        checks++;
        if (state !== ST_RUN || fault !== 1'b0 || psv !== 7'd30) begin
            errors++;
            $display("FAIL stall_early: state=%0d fault=%0d psv=%0d expected %0d 0 30", state, fault, psv, ST_RUN);
        end
        wait_until(t0 + STALL_MIN / RAMP_STEP + STALL_TICKS);
        checks++;
        if (state !== ST_FAULT || fault !== 1'b1 || stall_l !== !right_side || stall_r !== right_side ||
            cmd_ready !== 1'b0 || brk !== 1'b1 || psv !== 7'd0 || ste !== 8'd0) begin
            errors++;
            $display("FAIL stall_fault: state=%0d fault=%0d stl=%0d str=%0d rdy=%0d brk=%0d psv=%0d ste=%0d expected %0d 1 %0d %0d 0 1 0 0",
                     state, fault, stall_l, stall_r, cmd_ready, brk, psv, ste, ST_FAULT, !right_side, right_side);
        end
        cmd_valid = 1'b1;
        cmd_acc = 7'd50;
        cmd_ste = 8'd77;
        repeat (3) step();
        cmd_valid = 1'b0;
        checks++;
        if (state !== ST_FAULT || ste !== 8'd0 || psv !== 7'd0) begin
            errors++;
            $display("FAIL stall_ignore_cmd: state=%0d ste=%0d psv=%0d expected %0d 0 0", state, ste, psv, ST_FAULT);
        end
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        checks++;
        if (state !== ST_IDLE || fault !== 1'b0 || stall_l !== 1'b0 || stall_r !== 1'b0 || brk !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear: state=%0d fault=%0d stl=%0d str=%0d brk=%0d expected %0d 0 0 0 0",
                     state, fault, stall_l, stall_r, brk, ST_IDLE);
        end
    endtask

    task automatic test_priority();
        int t0;
        apply_reset();
        align();
        send(30, $urandom_range(0, 255), 1'b0);
        t0 = tk;
        // last left-edge change lands on tick WDOG-STALL, so both expire together
        wait_until(t0 + WDOG_TICKS - STALL_TICKS - 1);
        run_l = 1'b0;
        wait_until(t0 + WDOG_TICKS - 1);
        checks++;
        if (state !== ST_RUN) begin
            errors++;
            $display("FAIL prio_early: state=%0d expected %0d", state, ST_RUN);
        end
        wait_until(t0 + WDOG_TICKS);
        checks++;
        if (state !== ST_FAULT || stall_l !== 1'b1 || stall_r !== 1'b0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL prio_stall_over_wdog: state=%0d stl=%0d str=%0d fault=%0d expected %0d 1 0 1",
                     state, stall_l, stall_r, fault, ST_FAULT);
        end
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_brake();
        test_watchdog();
        test_stall(1'b0);
        test_stall(1'b1);
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end
endmodule
